// File: rtl/sample_tracker_pkg.sv
// -----------------------------------------------------------------------------
// sample_tracker_pkg
// Shared definitions for the sample_tracker block:
//   - default values of the WIDTH, CHANNELS, CNT_W and TS_W parameters
//   - chan_state_t: the state one channel keeps, at the default widths
// No ports (package).
// -----------------------------------------------------------------------------
package sample_tracker_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_TS_W     = 32;

  // Per-channel state at the default configuration. Modules built with other
  // widths declare a local struct with the same field order.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] q;
    logic [DEF_CNT_W-1:0] cnt;
    logic [DEF_TS_W-1:0]  ts;
    logic                 changed;
    logic                 sat;
  } chan_state_t;

endpackage : sample_tracker_pkg

// File: rtl/sample_tracker_chan.sv
// -----------------------------------------------------------------------------
// sample_tracker_chan
// One channel of the sample tracker. It captures d when en is high, records
// the cycle-counter value of the capture and counts the captures. It also
// raises a one-cycle pulse when a capture alters the held value.
//
// Optional feature (macro SAMPLE_TRACKER_SAT_EN):
//   defined   -> cnt saturates at all-ones and sets the sticky sat flag
//   undefined -> cnt wraps to 0 and sat stays 0
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   clr      in   synchronous clear of all channel state (wins over en)
//   en       in   capture enable
//   d        in   [WIDTH-1:0] data to capture
//   cyc      in   [TS_W-1:0]  current cycle-counter value
//   q        out  [WIDTH-1:0] captured data
//   cnt      out  [CNT_W-1:0] capture count
//   ts       out  [TS_W-1:0]  cyc value at the last capture
//   changed  out  pulse: the last capture altered q
//   sat      out  sticky counter-saturated flag
// -----------------------------------------------------------------------------
module sample_tracker_chan
  import sample_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TS_W  = DEF_TS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [TS_W-1:0]  cyc,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] cnt,
  output logic [TS_W-1:0]  ts,
  output logic             changed,
  output logic             sat
);

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic [TS_W-1:0]  ts;
    logic             changed;
    logic             sat;
  } state_t;

  state_t st;
  state_t st_nxt;

  always_comb begin
    // NOTE: every field gets a default first, so no path through this block
    // leaves a variable unassigned and no latch is inferred.
    st_nxt         = st;
    st_nxt.changed = 1'b0;
    if (clr) begin
      st_nxt = '0;
    end else if (en) begin
      st_nxt.q       = d;
      st_nxt.ts      = cyc;
      st_nxt.changed = (d != st.q);
`ifdef SAMPLE_TRACKER_SAT_EN
      // At all-ones the count holds and the attempt to go past it is flagged.
      if (&st.cnt) begin
        st_nxt.sat = 1'b1;
      end else begin
        st_nxt.cnt = st.cnt + CNT_W'(1);
      end
`else
      st_nxt.cnt = st.cnt + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge.
    if (rst) begin
      st <= '0;
    end else begin
      st <= st_nxt;
    end
  end

  assign q       = st.q;
  assign cnt     = st.cnt;
  assign ts      = st.ts;
  assign changed = st.changed;
  assign sat     = st.sat;

endmodule : sample_tracker_chan

// File: rtl/sample_tracker.sv
// -----------------------------------------------------------------------------
// sample_tracker
// Multi-channel sample tracker. A free-running cycle counter supplies the
// timestamps; each channel is an independent sample_tracker_chan, and their
// outputs are packed onto flat buses with channel k at slice k.
//
// Optional feature (macro SAMPLE_TRACKER_SAT_EN): saturating capture counters
// with a sticky sat flag; without it the counters wrap and sat is 0.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   clr      in   synchronous clear of all channel state (cyc unaffected)
//   en       in   [CHANNELS-1:0]        per-channel capture enable
//   d        in   [CHANNELS*WIDTH-1:0]  channel k data at [k*WIDTH +: WIDTH]
//   q        out  [CHANNELS*WIDTH-1:0]  captured data, same packing
//   cnt      out  [CHANNELS*CNT_W-1:0]  per-channel capture count
//   ts       out  [CHANNELS*TS_W-1:0]   cyc value at last capture
//   changed  out  [CHANNELS-1:0]        pulse: last capture altered q
//   sat      out  [CHANNELS-1:0]        sticky counter-saturated flag
//   cyc      out  [TS_W-1:0]            free-running cycle counter
// -----------------------------------------------------------------------------
module sample_tracker
  import sample_tracker_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TS_W     = DEF_TS_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*CNT_W-1:0] cnt,
  output logic [CHANNELS*TS_W-1:0]  ts,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS-1:0]       sat,
  output logic [TS_W-1:0]           cyc
);

  // Wraps naturally at 2^TS_W; clr deliberately does not touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= '0;
    end else begin
      cyc <= cyc + TS_W'(1);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    sample_tracker_chan #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .TS_W  (TS_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .en      (en[k]),
      .d       (d[k*WIDTH +: WIDTH]),
      .cyc     (cyc),
      .q       (q[k*WIDTH +: WIDTH]),
      .cnt     (cnt[k*CNT_W +: CNT_W]),
      .ts      (ts[k*TS_W +: TS_W]),
      .changed (changed[k]),
      .sat     (sat[k])
    );
  end

endmodule : sample_tracker

// File: tb/tb_sample_tracker.sv
// -----------------------------------------------------------------------------
// tb_sample_tracker
// Drives two sample_tracker instances with the same inputs:
//   u_dut_a : default parameters (WIDTH 4, CHANNELS 2, CNT_W 8, TS_W 32)
//   u_dut_b : CNT_W 2, TS_W 4, so counter and cycle-counter wrap are reachable
// A behavioural model kept per instance predicts every output each cycle.
// Honours SAMPLE_TRACKER_SAT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_sample_tracker;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [1:0] en;
  logic [7:0] d;

  logic [7:0]  qa;
  logic [15:0] cnta;
  logic [63:0] tsa;
  logic [1:0]  cha, sata;
  logic [31:0] cyca;

  logic [7:0]  qb;
  logic [3:0]  cntb;
  logic [7:0]  tsb;
  logic [1:0]  chb, satb;
  logic [3:0]  cycb;

  sample_tracker u_dut_a (
    .clk (clk), .rst (rst), .clr (clr), .en (en), .d (d),
    .q (qa), .cnt (cnta), .ts (tsa), .changed (cha), .sat (sata), .cyc (cyca)
  );

  sample_tracker #(.WIDTH(4), .CHANNELS(2), .CNT_W(2), .TS_W(4)) u_dut_b (
    .clk (clk), .rst (rst), .clr (clr), .en (en), .d (d),
    .q (qb), .cnt (cntb), .ts (tsb), .changed (chb), .sat (satb), .cyc (cycb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint unsigned mq  [2][2];
  longint unsigned mcnt[2][2];
  longint unsigned mts [2][2];
  longint unsigned mch [2][2];
  longint unsigned msat[2][2];
  longint unsigned mcyc[2];

  function automatic longint unsigned cnt_max(int i);
    return (i == 0) ? 64'd255 : 64'd3;
  endfunction

  function automatic longint unsigned ts_mod(int i);
    return (i == 0) ? 64'h1_0000_0000 : 64'd16;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 0;
      for (int k = 0; k < 2; k++) begin
        mq[i][k] = 0; mcnt[i][k] = 0; mts[i][k] = 0; mch[i][k] = 0; msat[i][k] = 0;
      end
    end
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        longint unsigned dk;
        dk = longint'((d >> (4 * k)) & 8'hF);
        mch[i][k] = 0;
        if (rst || clr) begin
          mq[i][k] = 0; mcnt[i][k] = 0; mts[i][k] = 0; msat[i][k] = 0;
        end else if (en[k]) begin
          mch[i][k] = (dk != mq[i][k]) ? 1 : 0;
          mq[i][k]  = dk;
          mts[i][k] = mcyc[i];
`ifdef SAMPLE_TRACKER_SAT_EN
          if (mcnt[i][k] + 1 > cnt_max(i)) msat[i][k] = 1;
          else                             mcnt[i][k] = mcnt[i][k] + 1;
`else
          mcnt[i][k] = (mcnt[i][k] + 1) % (cnt_max(i) + 1);
`endif
        end
      end
      mcyc[i] = rst ? 0 : (mcyc[i] + 1) % ts_mod(i);
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, " a.cyc"}, 64'(cyca), mcyc[0]);
    check({ph, " b.cyc"}, 64'(cycb), mcyc[1]);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s a.q%0d", ph, k),   64'(qa[k*4 +: 4]),    mq[0][k]);
      check($sformatf("%s a.cnt%0d", ph, k), 64'(cnta[k*8 +: 8]),  mcnt[0][k]);
      check($sformatf("%s a.ts%0d", ph, k),  64'(tsa[k*32 +: 32]), mts[0][k]);
      check($sformatf("%s a.chg%0d", ph, k), 64'(cha[k]),          mch[0][k]);
      check($sformatf("%s a.sat%0d", ph, k), 64'(sata[k]),         msat[0][k]);
      check($sformatf("%s b.q%0d", ph, k),   64'(qb[k*4 +: 4]),    mq[1][k]);
      check($sformatf("%s b.cnt%0d", ph, k), 64'(cntb[k*2 +: 2]),  mcnt[1][k]);
      check($sformatf("%s b.ts%0d", ph, k),  64'(tsb[k*4 +: 4]),   mts[1][k]);
      check($sformatf("%s b.chg%0d", ph, k), 64'(chb[k]),          mch[1][k]);
      check($sformatf("%s b.sat%0d", ph, k), 64'(satb[k]),         msat[1][k]);
    end
  endtask

  // One clock: edge, model update, sample 1 time unit later.
  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(ph);
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int unsigned seq_b[5];

  initial begin
    rst = 1'b1; clr = 1'b0; en = 2'b00; d = 8'h00;
    model_reset();
    #1;
    compare_all("por");
    @(negedge clk);
    rst = 1'b0;

    // Capture at cyc == 10 into channel 0 only.
    while (mcyc[0] != 10) step("idle");
    en = 2'b01; d = 8'h73;
    step("cap");
    check("cap q0",  64'(qa[3:0]),  64'd3);
    check("cap ts0", 64'(tsa[31:0]), 64'd10);
    check("cap cnt0", 64'(cnta[7:0]), 64'd1);
    check("cap chg", 64'(cha), 64'd1);
    check("cap q1",  64'(qa[7:4]),  64'd0);
    en = 2'b00;
    step("cap+1");
    check("cap+1 chg", 64'(cha), 64'd0);

    // Capture of an identical value: count/timestamp move, no change pulse.
    en = 2'b01; d = 8'h03;
    step("same");
    check("same cnt0", 64'(cnta[7:0]), 64'd2);
    check("same ts0",  64'(tsa[31:0]), 64'd12);
    check("same chg0", 64'(cha[0]), 64'd0);

    // Counter wrap / saturation on the CNT_W=2 instance.
    en = 2'b00; clr = 1'b1;
    step("clr");
    clr = 1'b0;
`ifdef SAMPLE_TRACKER_SAT_EN
    seq_b = '{1, 2, 3, 3, 3};
`else
    seq_b = '{1, 2, 3, 0, 1};
`endif
    for (int i = 0; i < 5; i++) begin
      en = 2'b01; d = 8'($urandom);
      step("satrun");
      check($sformatf("satrun b.cnt0 #%0d", i), 64'(cntb[1:0]), 64'(seq_b[i]));
`ifdef SAMPLE_TRACKER_SAT_EN
      check($sformatf("satrun b.sat0 #%0d", i), 64'(satb[0]), (i >= 3) ? 64'd1 : 64'd0);
`else
      check($sformatf("satrun b.sat #%0d", i), 64'(satb), 64'd0);
`endif
    end

    // Asynchronous reset mid-run with q0 = A, cnt0 = 5 on the default instance.
    en = 2'b00; clr = 1'b1;
    step("clr2");
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = 2'b01; d = {4'($urandom), 4'hA};
      step("fillA");
    end
    check("pre-rst q0",   64'(qa[3:0]),  64'd10);
    check("pre-rst cnt0", 64'(cnta[7:0]), 64'd5);
    en = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async rst");
    check("async rst cyc", 64'(cyca), 64'd0);
    step("in rst");
    @(negedge clk);
    rst = 1'b0;
    step("post rst");
    check("post rst a.cyc", 64'(cyca), 64'd1);
    check("post rst b.cyc", 64'(cycb), 64'd1);

    // clr collides with en on both channels.
    en = 2'b01; d = 8'h05;
    step("q0=5");
    clr = 1'b1; en = 2'b11; d = 8'($urandom);
    step("clr+en");
    check("clr+en q",   64'(qa),  64'd0);
    check("clr+en cnt", 64'(cnta), 64'd0);
    check("clr+en ts",  64'(tsa), 64'd0);
    clr = 1'b0; en = 2'b00;

    // Timestamp at the top of the TS_W=4 cycle counter, then its wrap.
    while (mcyc[1] != 15) step("towrap");
    check("b.cyc at 15", 64'(cycb), 64'd15);
    en = 2'b11; d = 8'($urandom);
    step("wrapcap");
    check("wrap b.ts0", 64'(tsb[3:0]), 64'd15);
    check("wrap b.ts1", 64'(tsb[7:4]), 64'd15);
    check("wrap b.cyc", 64'(cycb), 64'd0);

    // Randomized traffic; small data range makes repeated values common.
    for (int i = 0; i < 400; i++) begin
      en  = 2'($urandom_range(0, 3));
      d   = {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      if (($urandom & 1) == 1) d = 8'($urandom);
      clr = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sample_tracker
